javk_uart: RTL and testbench



---
 rtl/javk_uart_pkg.sv | 18 +
 rtl/javk_uart_fifo.sv | 41 ++++
 rtl/javk_uart.sv | 157 +++++++++++++++
 tb/tb_javk_uart.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/javk_uart_pkg.sv
// javk_uart_pkg: register map, status bit positions and FSM encodings for javk_uart
package javk_uart_pkg;
  localparam logic [1:0] UART_DATA   = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;
  localparam logic [1:0] UART_DIV_LO = 2'd2;
  localparam logic [1:0] UART_DIV_HI = 2'd3;
  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_VALID = 2;
  localparam int ST_RX_OVR   = 3;
  localparam int ST_TX_DROP  = 4;
  localparam int ST_RX_FERR  = 5;
  localparam int ST_TX_IE    = 7;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;
endpackage

// File: rtl/javk_uart_fifo.sv
// javk_uart_fifo: synchronous FIFO; a push into a full FIFO is taken when a pop frees the slot in the same cycle
module javk_uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic do_push, do_pop;
  assign empty = wptr_q == rptr_q;
  assign full = wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]};
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata = mem_q[rptr_q[AW-1:0]];
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wptr_q[AW-1:0]] = wdata;
    wptr_d = wptr_q + {{AW{1'b0}}, do_push};
    rptr_d = rptr_q + {{AW{1'b0}}, do_pop};
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end
endmodule

// File: rtl/javk_uart.sv
// javk_uart: memory-mapped 8N1 UART with TX FIFO, RX holding register and programmable bit divider
module javk_uart
  import javk_uart_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFF00,
  parameter logic [15:0] CLK_DIV    = 16'd104,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        stb,
  input  logic        rw,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        oe,
  output logic        txd,
  input  logic        rxd,
  output logic        irq
);
  logic [15:0] off, reload, half;
  logic hit, wr, rd_data, rd_stat, push, pop, full, empty, rx_done, s2, prev;
  logic [7:0] fifo_out, status;
  logic [15:0] div_q, div_d, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0] rx_data_q, rx_data_d, tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [2:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d, sync_q, sync_d;
  logic [1:0] tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic tx_ie_q, tx_ie_d, tx_drop_q, tx_drop_d, rx_valid_q, rx_valid_d;
  logic rx_ovr_q, rx_ovr_d, rx_ferr_q, rx_ferr_d, txd_q, txd_d;
  // addresses below BASE_ADDR wrap to large offsets and fall outside the window
  assign off = addr - BASE_ADDR;
  assign hit = off < 16'd4;
  assign oe = stb && !rw && hit;
  assign wr = stb && rw && hit;
  assign rd_data = oe && off[1:0] == UART_DATA;
  assign rd_stat = oe && off[1:0] == UART_STATUS;
  assign push = wr && off[1:0] == UART_DATA;
  assign reload = div_q == 16'd0 ? 16'd0 : div_q - 16'd1;
  assign half = div_q < 16'd2 ? 16'd0 : (div_q >> 1) - 16'd1;
  assign s2 = sync_q[1];
  assign prev = sync_q[2];
  assign txd = txd_q;
  assign irq = rx_valid_q | (empty & tx_ie_q);
  javk_uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .wdata(wdata), .pop(pop),
    .rdata(fifo_out), .full(full), .empty(empty)
  );
  always_comb begin
    status = '0;
    status[ST_TX_FULL] = full;
    status[ST_TX_EMPTY] = empty;
    status[ST_RX_VALID] = rx_valid_q;
    status[ST_RX_OVR] = rx_ovr_q;
    status[ST_TX_DROP] = tx_drop_q;
    status[ST_RX_FERR] = rx_ferr_q;
    status[ST_TX_IE] = tx_ie_q;
    rdata = !oe ? 8'h00 : off[1:0] == UART_DATA ? rx_data_q : off[1:0] == UART_STATUS ? status :
            off[1:0] == UART_DIV_LO ? div_q[7:0] : div_q[15:8];
  end
  always_comb begin
    pop = 1'b0;
    tx_st_d = tx_st_q;
    tx_cnt_d = tx_cnt_q - 16'd1;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    if (tx_st_q == S_IDLE) begin
      tx_cnt_d = reload;
      if (!empty) begin
        pop = 1'b1;
        tx_sh_d = fifo_out;
        tx_st_d = S_START;
      end
    end else if (tx_cnt_q == 16'd0) begin
      tx_cnt_d = reload;
      tx_st_d = tx_st_q == S_START ? S_DATA : tx_st_q == S_STOP ? S_IDLE : tx_bit_q == 3'd7 ? S_STOP : S_DATA;
      if (tx_st_q == S_DATA) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 3'd1;
      end
    end
    txd_d = tx_st_q == S_START ? 1'b0 : tx_st_q == S_DATA ? tx_sh_q[0] : 1'b1;
  end
  always_comb begin
    sync_d = {sync_q[1:0], rxd};
    rx_done = 1'b0;
    rx_st_d = rx_st_q;
    rx_cnt_d = rx_cnt_q - 16'd1;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    if (rx_st_q == S_IDLE) begin
      rx_cnt_d = half;
      if (prev && !s2) rx_st_d = S_START;
    end else if (rx_cnt_q == 16'd0) begin
      rx_cnt_d = reload;
      if (rx_st_q == S_START) rx_st_d = s2 ? S_IDLE : S_DATA;
      if (rx_st_q == S_DATA) begin
        rx_sh_d = {s2, rx_sh_q[7:1]};
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d = rx_bit_q == 3'd7 ? S_STOP : S_DATA;
      end
      if (rx_st_q == S_STOP) begin
        rx_done = 1'b1;
        rx_st_d = S_IDLE;
      end
    end
  end
  // a same-cycle DATA read sees the old byte, so completion keeps rx_valid set and skips the overrun
  always_comb begin
    rx_data_d = rx_done ? rx_sh_q : rx_data_q;
    rx_valid_d = rx_done || (rx_valid_q && !rd_data);
    rx_ovr_d = (rx_done && rx_valid_q && !rd_data) || (rx_ovr_q && !rd_stat);
    rx_ferr_d = (rx_done && !s2) || (rx_ferr_q && !rd_stat);
    tx_drop_d = (push && full && !pop) || (tx_drop_q && !rd_stat);
    tx_ie_d = wr && off[1:0] == UART_STATUS ? wdata[7] : tx_ie_q;
    div_d = wr && off[1:0] == UART_DIV_LO ? {div_q[15:8], wdata} :
            wr && off[1:0] == UART_DIV_HI ? {wdata, div_q[7:0]} : div_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= CLK_DIV;
      tx_st_q <= S_IDLE;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      txd_q <= 1'b1;
      rx_st_q <= S_IDLE;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      sync_q <= 3'b111;
      rx_data_q <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      tx_drop_q <= 1'b0;
      tx_ie_q <= 1'b0;
    end else begin
      div_q <= div_d;
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      txd_q <= txd_d;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      sync_q <= sync_d;
      rx_data_q <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      rx_ovr_q <= rx_ovr_d;
      rx_ferr_q <= rx_ferr_d;
      tx_drop_q <= tx_drop_d;
      tx_ie_q <= tx_ie_d;
    end
  end
endmodule

// File: tb/tb_javk_uart.sv
// tb_javk_uart: directed register, TX, RX and reset checks of javk_uart at div 4 and div 0
module tb_javk_uart;
  logic clk = 1'b0, rst = 1'b1, stb = 1'b0, rw = 1'b0, rxd = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [7:0] wdata = 8'h00, rdata;
  logic oe, txd, irq, last_oe, txd_prev = 1'b1;
  int n_assert = 0, n_fail = 0, fe_cnt = 0, fe0 = 0;
  logic [7:0] b;
  javk_uart #(.BASE_ADDR(16'hFF00), .CLK_DIV(16'd4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .stb(stb), .rw(rw), .wdata(wdata),
    .rdata(rdata), .oe(oe), .txd(txd), .rxd(rxd), .irq(irq)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    txd_prev <= txd;
    if (txd_prev && !txd) fe_cnt <= fe_cnt + 1;
  end
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic wr(input logic [15:0] a, input logic [7:0] v);
    @(negedge clk);
    stb = 1'b1; rw = 1'b1; addr = a; wdata = v;
    @(posedge clk);
    #1 stb = 1'b0; rw = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
    @(negedge clk);
    stb = 1'b1; rw = 1'b0; addr = a;
    #1 last_oe = oe;
    chk(tag, {8'h00, rdata}, {8'h00, exp});
    @(posedge clk);
    #1 stb = 1'b0;
  endtask
  task automatic send(input logic [7:0] v, input logic stop);
    @(negedge clk) rxd = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) rxd = v[i];
      repeat (3) @(negedge clk);
    end
    @(negedge clk) rxd = stop;
    repeat (3) @(negedge clk);
    @(negedge clk) rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rst_txd", {15'h0, txd}, 16'h1);
    chk("rst_irq", {15'h0, irq}, 16'h0);
    chk("rst_oe", {15'h0, oe}, 16'h0);
    chk("rst_rdata", {8'h0, rdata}, 16'h0);
    rd("rst_status", 16'hFF01, 8'h02);
    chk("oe_in_window", {15'h0, last_oe}, 16'h1);
    rd("rst_div_lo", 16'hFF02, 8'h04);
    rd("rst_div_hi", 16'hFF03, 8'h00);
    rd("out_win_hi", 16'hFF04, 8'h00);
    chk("oe_out_hi", {15'h0, last_oe}, 16'h0);
    rd("out_win_lo", 16'hFEFF, 8'h00);
    chk("oe_out_lo", {15'h0, last_oe}, 16'h0);
    wr(16'h0001, 8'h80);
    rd("out_win_write", 16'hFF01, 8'h02);
    wr(16'hFF01, 8'h80);
    @(negedge clk);
    chk("irq_tx_ie", {15'h0, irq}, 16'h1);
    rd("status_ie", 16'hFF01, 8'h82);
    wr(16'hFF01, 8'h00);
    // A5 at div 4: start bit visible two cycles after the write edge
    wr(16'hFF00, 8'hA5);
    repeat (2) @(negedge clk);
    chk("tx_lat_idle", {15'h0, txd}, 16'h1);
    @(negedge clk);
    chk("tx_lat_start", {15'h0, txd}, 16'h0);
    b = 8'hA5;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tx_a5_bit%0d", i), {15'h0, txd}, {15'h0, b[i]});
      repeat (4) @(negedge clk);
    end
    chk("tx_a5_stop", {15'h0, txd}, 16'h1);
    repeat (5) @(negedge clk);
    rd("tx_done_status", 16'hFF01, 8'h02);
    fe0 = fe_cnt;
    for (int i = 0; i < 6; i++) wr(16'hFF00, 8'hFF);
    rd("ovf_status1", 16'hFF01, 8'h11);
    rd("ovf_status2", 16'hFF01, 8'h01);
    repeat (260) @(negedge clk);
    chk("ovf_frames", 16'(fe_cnt - fe0), 16'd5);
    rd("ovf_status3", 16'hFF01, 8'h02);
    send(8'h3C, 1'b1);
    chk("rx_irq", {15'h0, irq}, 16'h1);
    rd("rx_status", 16'hFF01, 8'h06);
    rd("rx_data", 16'hFF00, 8'h3C);
    rd("rx_status_clr", 16'hFF01, 8'h02);
    send(8'h11, 1'b1);
    send(8'h22, 1'b1);
    rd("ovr_status", 16'hFF01, 8'h0E);
    rd("ovr_data", 16'hFF00, 8'h22);
    rd("ovr_status_clr", 16'hFF01, 8'h02);
    send(8'h5A, 1'b0);
    rd("ferr_status", 16'hFF01, 8'h26);
    rd("ferr_data", 16'hFF00, 8'h5A);
    @(negedge clk) rxd = 1'b0;
    @(negedge clk) rxd = 1'b1;
    repeat (60) @(negedge clk);
    rd("glitch_status", 16'hFF01, 8'h02);
    wr(16'hFF00, 8'h00);
    wr(16'hFF00, 8'h00);
    wr(16'hFF00, 8'h00);
    repeat (12) @(negedge clk);
    chk("mid_frame_txd", {15'h0, txd}, 16'h0);
    rst = 1'b1;
    @(posedge clk);
    #1 chk("rst_mid_txd", {15'h0, txd}, 16'h1);
    @(negedge clk) rst = 1'b0;
    rd("rst_mid_status", 16'hFF01, 8'h02);
    repeat (20) @(negedge clk);
    chk("rst_mid_idle", {15'h0, txd}, 16'h1);
    wr(16'hFF02, 8'h00);
    rd("div0_lo", 16'hFF02, 8'h00);
    wr(16'hFF00, 8'h5A);
    b = 8'h5A;
    repeat (2) @(negedge clk);
    chk("div0_idle", {15'h0, txd}, 16'h1);
    @(negedge clk);
    chk("div0_start", {15'h0, txd}, 16'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("div0_bit%0d", i), {15'h0, txd}, {15'h0, b[i]});
    end
    @(negedge clk);
    chk("div0_stop", {15'h0, txd}, 16'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
